// File: rtl/arm_control_unit.sv
// Control unit for the single-cycle ARM datapath: decode, NZCV flags, condition check, memory stall FSM.
// Optional MEM_TIMEOUT_EN adds a MEMWAIT timeout that aborts the access and sets sticky MemErr.
module arm_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic [2:0]  ALUControl,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        MemReq,
    output logic        PCSrc,
    output logic        PCEn,
    output logic [3:0]  Flags,
    output logic        MemErr
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    typedef enum logic {EXEC, MEMWAIT} state_t;

    state_t     state, state_n;
    logic [3:0] cond, rd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       regw, memw, branch, is_mem, condex, pc_taken, timeout;
    logic [1:0] flagw;
    logic       unused_rn;

    // Instr carries bits [31:12] of the instruction word
    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    // Main and ALU decode
    always_comb begin
        RegSrc     = 2'b00;
        ImmSrc     = 2'b00;
        ALUSrc     = 1'b0;
        ALUControl = ALU_ADD;
        MemtoReg   = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        is_mem     = 1'b0;
        flagw      = 2'b00;
        case (op)
            2'b00: begin
                ALUSrc = funct[5];
                regw   = 1'b1;
                case (funct[4:1])
                    4'b0100: begin ALUControl = ALU_ADD; flagw = {2{funct[0]}};    end
                    4'b0010: begin ALUControl = ALU_SUB; flagw = {2{funct[0]}};    end
                    4'b0000: begin ALUControl = ALU_AND; flagw = {funct[0], 1'b0}; end
                    4'b1100: begin ALUControl = ALU_ORR; flagw = {funct[0], 1'b0}; end
                    4'b0001: begin ALUControl = ALU_EOR; flagw = {funct[0], 1'b0}; end
                    4'b1010: begin ALUControl = ALU_SUB; flagw = 2'b11; regw = 1'b0; end
                    default: regw = 1'b0;
                endcase
            end
            2'b01: begin
                ImmSrc     = 2'b01;
                ALUSrc     = 1'b1;
                ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
                is_mem     = 1'b1;
                if (funct[0]) begin
                    MemtoReg = 1'b1;
                    regw     = 1'b1;
                end else begin
                    RegSrc = 2'b10;
                    memw   = 1'b1;
                end
            end
            2'b10: begin
                RegSrc = 2'b01;
                ImmSrc = 2'b10;
                ALUSrc = 1'b1;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    // Condition check against the registered flags {N,Z,C,V}
    always_comb begin
        condex = 1'b0;
        case (cond)
            4'b0000: condex = Flags[2];
            4'b0001: condex = ~Flags[2];
            4'b0010: condex = Flags[1];
            4'b0011: condex = ~Flags[1];
            4'b0100: condex = Flags[3];
            4'b0101: condex = ~Flags[3];
            4'b0110: condex = Flags[0];
            4'b0111: condex = ~Flags[0];
            4'b1000: condex = Flags[1] & ~Flags[2];
            4'b1001: condex = ~Flags[1] | Flags[2];
            4'b1010: condex = (Flags[3] == Flags[0]);
            4'b1011: condex = (Flags[3] != Flags[0]);
            4'b1100: condex = ~Flags[2] & (Flags[3] == Flags[0]);
            4'b1101: condex = Flags[2] | (Flags[3] != Flags[0]);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign pc_taken = (branch | ((rd == 4'd15) & regw)) & condex;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    assign timeout = (state == MEMWAIT) && (wait_cnt == CW'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            MemErr   <= 1'b0;
        end else begin
            wait_cnt <= (state == MEMWAIT) ? wait_cnt + CW'(1) : '0;
            if (timeout) MemErr <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (MEM_TIMEOUT == 0);
    assign timeout    = 1'b0;
    assign MemErr     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EXEC;
        else        state <= state_n;
    end

    // Next state and conditioned enables; stalls are cleared by reset asynchronously
    always_comb begin
        state_n  = state;
        PCEn     = 1'b0;
        MemReq   = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        PCSrc    = 1'b0;
        case (state)
            EXEC: begin
                PCSrc = pc_taken;
                if (is_mem && condex) begin
                    MemReq   = 1'b1;
                    MemWrite = memw;
                    if (MemReady) begin
                        PCEn     = 1'b1;
                        RegWrite = regw;
                    end else begin
                        state_n = MEMWAIT;
                    end
                end else begin
                    PCEn     = 1'b1;
                    RegWrite = regw & condex;
                    MemWrite = memw & condex;
                end
            end
            MEMWAIT: begin
                if (timeout) begin
                    PCEn    = 1'b1;
                    state_n = EXEC;
                end else begin
                    PCSrc    = pc_taken;
                    MemReq   = 1'b1;
                    MemWrite = memw;
                    if (MemReady) begin
                        PCEn     = 1'b1;
                        RegWrite = regw;
                        state_n  = EXEC;
                    end
                end
            end
            default: state_n = EXEC;
        endcase
        if (!reset) begin
            PCEn     = 1'b0;
            MemReq   = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            PCSrc    = 1'b0;
        end
    end

    // Flag register: NZ and CV halves written independently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags <= 4'b0000;
        end else if (PCEn && condex) begin
            if (flagw[1]) Flags[3:2] <= ALUFlags[3:2];
            if (flagw[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed self-checking bench for arm_control_unit (default build; timeout steps under MEM_TIMEOUT_EN).
module tb_arm_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [2:0]  ALUControl;
    logic        MemtoReg;
    logic        MemWrite;
    logic        MemReq;
    logic        PCSrc;
    logic        PCEn;
    logic [3:0]  Flags;
    logic        MemErr;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADD   = 32'hE0855004;
    localparam logic [31:0] I_SUBS  = 32'hE0555004;
    localparam logic [31:0] I_ADDEQ = 32'h00855004;
    localparam logic [31:0] I_ADDNE = 32'h10855004;
    localparam logic [31:0] I_ANDS  = 32'hE0155004;
    localparam logic [31:0] I_CMP   = 32'hE1550004;
    localparam logic [31:0] I_BADS  = 32'hE0755004;
    localparam logic [31:0] I_OP11  = 32'hEC000000;
    localparam logic [31:0] I_NV    = 32'hF0855004;
    localparam logic [31:0] I_ADDPC = 32'hE085F004;
    localparam logic [31:0] I_B     = 32'hEA000002;
    localparam logic [31:0] I_BEQ   = 32'h0A000002;
    localparam logic [31:0] I_BGE   = 32'hAA000002;
    localparam logic [31:0] I_BLT   = 32'hBA000002;
    localparam logic [31:0] I_STR   = 32'hE5851000;
    localparam logic [31:0] I_STRD  = 32'hE5051000;
    localparam logic [31:0] I_LDR   = 32'hE5951000;

    arm_control_unit #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
        .ALUControl(ALUControl), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemReq(MemReq),
        .PCSrc(PCSrc), .PCEn(PCEn), .Flags(Flags), .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one instruction mid-cycle and settle before checking
    task automatic drive(input logic [31:0] ins, input logic [3:0] af, input logic rdy);
        @(negedge clk);
        Instr    = ins[31:12];
        ALUFlags = af;
        MemReady = rdy;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b0;
        Instr    = I_ADD[31:12];
        ALUFlags = 4'b0000;
        MemReady = 1'b0;
        #1;
        chk("rst_pcen", PCEn, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_memreq", MemReq, 0);
        chk("rst_flags", Flags, 0);
        chk("rst_memerr", MemErr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        drive(I_ADD, 4'b0000, 1'b0);
        chk("add_regwrite", RegWrite, 1);
        chk("add_aluctl", ALUControl, 0);
        chk("add_alusrc", ALUSrc, 0);
        chk("add_regsrc", RegSrc, 0);
        chk("add_pcsrc", PCSrc, 0);
        chk("add_pcen", PCEn, 1);
        chk("add_memreq", MemReq, 0);

        drive(I_SUBS, 4'b0100, 1'b0);
        chk("subs_aluctl", ALUControl, 1);
        chk("subs_regwrite", RegWrite, 1);
        after_edge();
        chk("subs_flags", Flags, 4'b0100);

        drive(I_ADDEQ, 4'b0000, 1'b0);
        chk("addeq_regwrite", RegWrite, 1);
        drive(I_ADDNE, 4'b0000, 1'b0);
        chk("addne_regwrite", RegWrite, 0);
        chk("addne_pcen", PCEn, 1);

        drive(I_ANDS, 4'b1111, 1'b0);
        chk("ands_aluctl", ALUControl, 2);
        after_edge();
        chk("ands_flags_nz_only", Flags, 4'b1100);

        drive(I_CMP, 4'b0011, 1'b0);
        chk("cmp_regwrite", RegWrite, 0);
        chk("cmp_aluctl", ALUControl, 1);
        after_edge();
        chk("cmp_flags", Flags, 4'b0011);

        drive(I_BADS, 4'b1111, 1'b0);
        chk("illegal_regwrite", RegWrite, 0);
        after_edge();
        chk("illegal_flags_kept", Flags, 4'b0011);

        drive(I_OP11, 4'b0000, 1'b0);
        chk("op11_regwrite", RegWrite, 0);
        chk("op11_memwrite", MemWrite, 0);
        chk("op11_pcsrc", PCSrc, 0);

        drive(I_NV, 4'b0000, 1'b0);
        chk("nv_regwrite", RegWrite, 0);

        drive(I_ADDPC, 4'b0000, 1'b0);
        chk("addpc_pcsrc", PCSrc, 1);
        chk("addpc_regwrite", RegWrite, 1);

        drive(I_B, 4'b0000, 1'b0);
        chk("b_pcsrc", PCSrc, 1);
        chk("b_immsrc", ImmSrc, 2);
        chk("b_alusrc", ALUSrc, 1);
        chk("b_regsrc", RegSrc, 1);
        chk("b_regwrite", RegWrite, 0);

        drive(I_BEQ, 4'b0000, 1'b0);
        chk("beq_z0_pcsrc", PCSrc, 0);
        drive(I_BGE, 4'b0000, 1'b0);
        chk("bge_pcsrc", PCSrc, 0);
        drive(I_BLT, 4'b0000, 1'b0);
        chk("blt_pcsrc", PCSrc, 1);

        drive(I_STR, 4'b0000, 1'b1);
        chk("str_memwrite", MemWrite, 1);
        chk("str_memreq", MemReq, 1);
        chk("str_pcen", PCEn, 1);
        chk("str_regwrite", RegWrite, 0);
        chk("str_regsrc", RegSrc, 2);
        chk("str_immsrc", ImmSrc, 1);
        chk("str_aluctl", ALUControl, 0);

        drive(I_STRD, 4'b0000, 1'b0);
        chk("strd_aluctl", ALUControl, 1);
        chk("strd_memwrite_stall", MemWrite, 1);
        chk("strd_pcen_stall", PCEn, 0);
        drive(I_STRD, 4'b0000, 1'b1);
        chk("strd_done_pcen", PCEn, 1);
        chk("strd_done_memwrite", MemWrite, 1);

        for (int i = 0; i < 3; i++) begin
            drive(I_LDR, 4'b0000, 1'b0);
            chk("ldr_wait_memreq", MemReq, 1);
            chk("ldr_wait_pcen", PCEn, 0);
            chk("ldr_wait_regwrite", RegWrite, 0);
        end
        drive(I_LDR, 4'b0000, 1'b1);
        chk("ldr_done_memreq", MemReq, 1);
        chk("ldr_done_pcen", PCEn, 1);
        chk("ldr_done_regwrite", RegWrite, 1);
        chk("ldr_done_memtoreg", MemtoReg, 1);

        drive(I_ADD, 4'b0000, 1'b0);
        chk("post_ldr_exec_pcen", PCEn, 1);

`ifdef MEM_TIMEOUT_EN
        drive(I_STR, 4'b0000, 1'b0);
        chk("to_first_pcen", PCEn, 0);
        n = 0;
        while (n < 40 && PCEn !== 1'b1) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("to_abort_cycle", 8'(n), 16);
        chk("to_abort_memwrite", MemWrite, 0);
        chk("to_abort_memreq", MemReq, 0);
        chk("to_abort_regwrite", RegWrite, 0);
        after_edge();
        chk("to_memerr", MemErr, 1);
`else
        n = 0;
`endif

        drive(I_LDR, 4'b0000, 1'b0);
        after_edge();
        chk("rstmw_stalled", PCEn, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmw_regwrite", RegWrite, 0);
        chk("rstmw_memreq", MemReq, 0);
        chk("rstmw_pcen", PCEn, 0);
        chk("rstmw_flags", Flags, 0);
        chk("rstmw_memerr", MemErr, 0);
        @(negedge clk);
        reset    = 1'b1;
        Instr    = I_ADD[31:12];
        MemReady = 1'b0;
        #1;
        chk("rstmw_exec_pcen", PCEn, 1);
        chk("rstmw_exec_memreq", MemReq, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
